// File: rtl/br_fifo_shared_pstatic_cfg_seq.sv
// Configuration sequencer for the shared pseudo-static multi-FIFO: packs per-FIFO sizes
// into base/bound ranges while holding the FIFO in reset, and re-sequences on request.
module br_fifo_shared_pstatic_cfg_seq #(
  parameter int NumFifos        = 2,
  parameter int Depth           = 2,
  parameter int DrainHoldCycles = 2,
  localparam int AddrWidth      = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int SizeWidth      = (Depth + 1 > 1) ? $clog2(Depth + 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumFifos*SizeWidth-1:0] cfg_size,
  input  logic                          cfg_req_valid,
  output logic                          cfg_req_ready,
  input  logic [NumFifos-1:0]           fifo_pop_empty,
  output logic                          quiesce,
  output logic                          fifo_rst,
  output logic [NumFifos*AddrWidth-1:0] config_base,
  output logic [NumFifos*AddrWidth-1:0] config_bound,
  output logic                          config_done,
  output logic                          config_error,
  output logic [2:0]                    dbg_state
);

  localparam int IdxWidth = (NumFifos > 1) ? $clog2(NumFifos) : 1;
  localparam int CntWidth = (DrainHoldCycles > 0) ? $clog2(DrainHoldCycles + 1) : 1;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_COMPUTE = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  // Handshake: a request is taken on any edge where cfg_req_valid && cfg_req_ready;
  // valid seen while ready is low is dropped, never queued.

  state_t                 state_q;
  logic [IdxWidth-1:0]    i_q;
  logic [SizeWidth:0]     acc_q;
  logic                   err_q;
  logic [CntWidth-1:0]    cnt_q;
  logic [SizeWidth-1:0]   size_q  [NumFifos];
  logic [AddrWidth-1:0]   base_q  [NumFifos];
  logic [AddrWidth-1:0]   bound_q [NumFifos];

  logic [SizeWidth-1:0]   cur_size;
  logic [SizeWidth:0]     acc_sum;
  logic [AddrWidth-1:0]   base_w;
  logic [AddrWidth-1:0]   bound_w;
  logic                   err_any;
  logic                   last_idx;

  always_comb begin
    cur_size = size_q[i_q];
    acc_sum  = acc_q + {1'b0, cur_size};
    base_w   = AddrWidth'(acc_q);
    bound_w  = AddrWidth'(acc_q) + AddrWidth'(cur_size) - AddrWidth'(1);
    err_any  = err_q || (cur_size == '0) || (acc_sum > (SizeWidth+1)'(Depth));
    last_idx = (i_q == IdxWidth'(NumFifos - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOAD;
      fifo_rst      <= 1'b1;
      config_done   <= 1'b0;
      config_error  <= 1'b0;
      quiesce       <= 1'b0;
      cfg_req_ready <= 1'b0;
      i_q           <= '0;
      acc_q         <= '0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      for (int k = 0; k < NumFifos; k++) begin
        size_q[k]  <= '0;
        base_q[k]  <= '0;
        bound_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          for (int k = 0; k < NumFifos; k++) size_q[k] <= cfg_size[k*SizeWidth +: SizeWidth];
          i_q          <= '0;
          acc_q        <= '0;
          err_q        <= 1'b0;
          config_error <= 1'b0;
          fifo_rst     <= 1'b1;
          state_q      <= S_COMPUTE;
        end
        S_COMPUTE: begin
          base_q[i_q]  <= base_w;
          bound_q[i_q] <= bound_w;
          acc_q        <= acc_sum;
          err_q        <= err_any;
          i_q          <= i_q + 1'b1;
          if (last_idx) begin
            i_q           <= '0;
            cfg_req_ready <= 1'b1;
            if (err_any) begin
              state_q      <= S_ERROR;
              config_error <= 1'b1;
            end else begin
              state_q     <= S_RUN;
              fifo_rst    <= 1'b0;
              config_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cfg_req_valid) begin
            state_q       <= S_DRAIN;
            config_done   <= 1'b0;
            cfg_req_ready <= 1'b0;
            quiesce       <= 1'b1;
            cnt_q         <= '0;
          end
        end
        S_DRAIN: begin
          // Any non-empty report restarts the consecutive-empty count.
          if (&fifo_pop_empty) begin
            if (cnt_q == CntWidth'(DrainHoldCycles - 1)) begin
              state_q  <= S_LOAD;
              quiesce  <= 1'b0;
              fifo_rst <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        S_ERROR: begin
          if (cfg_req_valid) begin
            state_q       <= S_LOAD;
            config_error  <= 1'b0;
            cfg_req_ready <= 1'b0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  for (genvar g = 0; g < NumFifos; g++) begin : g_pack
    assign config_base[g*AddrWidth +: AddrWidth]  = base_q[g];
    assign config_bound[g*AddrWidth +: AddrWidth] = bound_q[g];
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_br_fifo_shared_pstatic_cfg_seq.sv
// Directed bench for the shared-FIFO configuration sequencer (4 FIFOs, depth 16, hold 2).
module tb_br_fifo_shared_pstatic_cfg_seq;

  localparam int NumFifos = 4;
  localparam int Depth    = 16;
  localparam int Hold     = 2;
  localparam int AW       = 4;
  localparam int SW       = 5;

  logic                   clk;
  logic                   rst;
  logic [NumFifos*SW-1:0] cfg_size;
  logic                   cfg_req_valid;
  logic                   cfg_req_ready;
  logic [NumFifos-1:0]    fifo_pop_empty;
  logic                   quiesce;
  logic                   fifo_rst;
  logic [NumFifos*AW-1:0] config_base;
  logic [NumFifos*AW-1:0] config_bound;
  logic                   config_done;
  logic                   config_error;
  logic [2:0]             dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  br_fifo_shared_pstatic_cfg_seq #(
    .NumFifos(NumFifos), .Depth(Depth), .DrainHoldCycles(Hold)
  ) dut (
    .clk(clk), .rst(rst), .cfg_size(cfg_size), .cfg_req_valid(cfg_req_valid),
    .cfg_req_ready(cfg_req_ready), .fifo_pop_empty(fifo_pop_empty), .quiesce(quiesce),
    .fifo_rst(fifo_rst), .config_base(config_base), .config_bound(config_bound),
    .config_done(config_done), .config_error(config_error), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sizes(input int a, input int b, input int c, input int d);
    cfg_size = {SW'(d), SW'(c), SW'(b), SW'(a)};
  endtask

  function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_layout(input string tag, input logic [15:0] eb, input logic [15:0] ed);
    check({tag, "_base"}, 32'(config_base), 32'(eb));
    check({tag, "_bound"}, 32'(config_bound), 32'(ed));
  endtask

  task automatic request;
    cfg_req_valid = 1'b1;
    step(1);
    cfg_req_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    cfg_req_valid  = 1'b0;
    fifo_pop_empty = '1;
    set_sizes(6, 2, 3, 5);
    step(2);
    check("rst_fifo_rst", 32'(fifo_rst), 32'd1);
    check("rst_done", 32'(config_done), 32'd0);
    check("rst_error", 32'(config_error), 32'd0);
    check("rst_ready", 32'(cfg_req_ready), 32'd0);
    check("rst_quiesce", 32'(quiesce), 32'd0);
    check_layout("rst", 16'h0, 16'h0);

    // Initial bring-up: release on the 5th edge.
    rst = 1'b0;
    step(4);
    check("boot_e4_fifo_rst", 32'(fifo_rst), 32'd1);
    check("boot_e4_done", 32'(config_done), 32'd0);
    step(1);
    check("boot_e5_fifo_rst", 32'(fifo_rst), 32'd0);
    check("boot_e5_done", 32'(config_done), 32'd1);
    check("boot_ready", 32'(cfg_req_ready), 32'd1);
    check_layout("boot", pack4(0, 6, 8, 11), pack4(5, 7, 10, 15));

    // Runtime reconfig with a FIFO still holding data, then a broken empty streak.
    fifo_pop_empty = 4'b1011;
    set_sizes(2, 2, 2, 10);
    request();
    check("drain_quiesce", 32'(quiesce), 32'd1);
    check("drain_fifo_rst", 32'(fifo_rst), 32'd0);
    check("drain_done", 32'(config_done), 32'd0);
    check("drain_ready", 32'(cfg_req_ready), 32'd0);
    step(3);
    check("drain_hold_fifo_rst", 32'(fifo_rst), 32'd0);
    check_layout("drain_stable", pack4(0, 6, 8, 11), pack4(5, 7, 10, 15));
    fifo_pop_empty = 4'b1111;
    step(1);
    check("streak1_fifo_rst", 32'(fifo_rst), 32'd0);
    fifo_pop_empty = 4'b1011;
    step(1);
    check("broken_fifo_rst", 32'(fifo_rst), 32'd0);
    fifo_pop_empty = 4'b1111;
    step(1);
    check("restart1_fifo_rst", 32'(fifo_rst), 32'd0);
    check("restart1_quiesce", 32'(quiesce), 32'd1);
    step(1);
    check("restart2_fifo_rst", 32'(fifo_rst), 32'd1);
    check("restart2_quiesce", 32'(quiesce), 32'd0);
    step(1);
    set_sizes(1, 1, 1, 1);
    step(3);
    check("recfg_e4_fifo_rst", 32'(fifo_rst), 32'd1);
    step(1);
    check("recfg_fifo_rst", 32'(fifo_rst), 32'd0);
    check("recfg_done", 32'(config_done), 32'd1);
    check_layout("recfg", pack4(0, 2, 4, 6), pack4(1, 3, 5, 15));

    // Oversubscribed layout lands in ERROR.
    set_sizes(6, 2, 3, 6);
    request();
    step(2);
    check("over_enter_fifo_rst", 32'(fifo_rst), 32'd1);
    step(5);
    check("over_error", 32'(config_error), 32'd1);
    check("over_fifo_rst", 32'(fifo_rst), 32'd1);
    check("over_ready", 32'(cfg_req_ready), 32'd1);
    check("over_done", 32'(config_done), 32'd0);

    // Recover from ERROR with an exactly-full layout.
    set_sizes(4, 4, 4, 4);
    request();
    check("recover_load_error", 32'(config_error), 32'd0);
    check("recover_load_ready", 32'(cfg_req_ready), 32'd0);
    step(5);
    check("recover_fifo_rst", 32'(fifo_rst), 32'd0);
    check("recover_done", 32'(config_done), 32'd1);
    check("recover_error", 32'(config_error), 32'd0);
    check_layout("recover", pack4(0, 4, 8, 12), pack4(3, 7, 11, 15));

    // Zero size is an error even when the total fits.
    set_sizes(8, 0, 4, 4);
    request();
    step(7);
    check("zero_error", 32'(config_error), 32'd1);
    check("zero_fifo_rst", 32'(fifo_rst), 32'd1);

    // Asynchronous reset in the middle of COMPUTE (i=2).
    set_sizes(6, 2, 3, 5);
    request();
    step(3);
    #1 rst = 1'b1;
    #1;
    check("async_fifo_rst", 32'(fifo_rst), 32'd1);
    check("async_ready", 32'(cfg_req_ready), 32'd0);
    check("async_error", 32'(config_error), 32'd0);
    check_layout("async", 16'h0, 16'h0);
    step(1);
    rst = 1'b0;
    step(4);
    check("post_async_e4_fifo_rst", 32'(fifo_rst), 32'd1);
    step(1);
    check("post_async_fifo_rst", 32'(fifo_rst), 32'd0);
    check("post_async_done", 32'(config_done), 32'd1);
    check_layout("post_async", pack4(0, 6, 8, 11), pack4(5, 7, 10, 15));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
